// File: rtl/gray_disp_pkg.sv
// rtl/gray_disp_pkg.sv - shared constants and helpers for the Gray-code receive display
package gray_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0110000;

    // Active-low abcdefg patterns, bit6 = a, indexed by hex digit value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [2:0] popcount(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/hex_to_seven_segment.sv
// rtl/hex_to_seven_segment.sv - combinational 4-bit hex to active-low seven-segment pattern
module hex_to_seven_segment
    import gray_disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/gray_to_binary_with_display.sv
// rtl/gray_to_binary_with_display.sv - synchronized Gray decoder with step checking and two-digit display
module gray_to_binary_with_display
    import gray_disp_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray,
    input  logic             clear_err,
    output logic [WIDTH-1:0] binary,
    output logic             changed,
    output logic             step_err,
    output logic [6:0]       seven_segment,
    output logic [1:0]       anode
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] binary_q, binary_d;
    logic             armed_q, armed_d;
    logic             changed_q, changed_d;
    logic             step_err_q, step_err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic [1:0]       anode_q, anode_d;
    logic [6:0]       seg_q, seg_d;

    logic [WIDTH-1:0] g_s;
    logic [2:0]       diff;
    logic             accept;
    logic             refresh_last;
    logic [6:0]       hex_seg;

    assign g_s = sync_q[SYNC_STAGES-1];

    hex_to_seven_segment u_hex (
        .hex (binary_q),
        .seg (hex_seg)
    );

    always_comb begin
        sync_d[0] = gray;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        diff      = popcount(g_s ^ prev_q);
        accept    = diff != 3'd0;
        prev_d    = accept ? g_s : prev_q;
        binary_d  = accept ? gray2bin(g_s) : binary_q;
        changed_d = accept;
        armed_d   = armed_q | accept;
        // A fresh error outranks a simultaneous clear
        step_err_d = (accept && armed_q && diff >= 3'd2) || (step_err_q && !clear_err);

        refresh_last = cnt_q == CNT_LAST;
        cnt_d        = refresh_last ? '0 : cnt_q + 1'b1;
        sel_d        = sel_q ^ refresh_last;

        anode_d = sel_q ? 2'b01 : 2'b10;
        seg_d   = sel_q ? (step_err_q ? SEG_E : SEG_BLANK) : hex_seg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            binary_q   <= '0;
            armed_q    <= 1'b0;
            changed_q  <= 1'b0;
            step_err_q <= 1'b0;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            anode_q    <= 2'b10;
            seg_q      <= 7'b0000001;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            binary_q   <= binary_d;
            armed_q    <= armed_d;
            changed_q  <= changed_d;
            step_err_q <= step_err_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            anode_q    <= anode_d;
            seg_q      <= seg_d;
        end
    end

    assign binary        = binary_q;
    assign changed       = changed_q;
    assign step_err      = step_err_q;
    assign seven_segment = seg_q;
    assign anode         = anode_q;

endmodule

// File: tb/tb_gray_to_binary_with_display.sv
// tb/tb_gray_to_binary_with_display.sv - scoreboard bench for gray_to_binary_with_display
module tb_gray_to_binary_with_display;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int RD = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] gray = '0;
    logic         clear_err = 1'b0;
    logic [W-1:0] binary;
    logic         changed;
    logic         step_err;
    logic [6:0]   seven_segment;
    logic [1:0]   anode;

    always #5 clk = ~clk;

    gray_to_binary_with_display #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .REFRESH_DIV (RD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .gray          (gray),
        .clear_err     (clear_err),
        .binary        (binary),
        .changed       (changed),
        .step_err      (step_err),
        .seven_segment (seven_segment),
        .anode         (anode)
    );

    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        logic [3:0] bin;
        logic       err;
        int         e;
    } exp_t;

    exp_t       sb_q [$];
    logic [3:0] hist [$];
    logic [3:0] m_prev, m_bin;
    logic       m_armed, m_err;
    int         m_edges;
    logic [1:0] exp_anode;
    logic [6:0] exp_seg;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] ref_decode(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    // Reference model: sample history stands in for the synchronizer delay
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist = '{4'h0, 4'h0};
            sb_q.delete();
            m_prev = 4'h0; m_bin = 4'h0; m_armed = 1'b0; m_err = 1'b0;
            m_edges = 0;
            exp_anode = 2'b10;
            exp_seg = 7'b0000001;
        end else begin
            int sel;
            int d;
            logic [3:0] s;
            logic new_err;
            sel = (m_edges / RD) % 2;
            exp_anode = (sel == 1) ? 2'b01 : 2'b10;
            exp_seg = (sel == 1) ? (m_err ? 7'b0110000 : 7'b1111111) : hex_tab[m_bin];
            hist.push_back(gray);
            s = hist.pop_front();
            d = $countones(s ^ m_prev);
            new_err = 1'b0;
            if (d > 0) begin
                new_err = m_armed && (d > 1);
                m_prev  = s;
                m_bin   = ref_decode(s);
                m_armed = 1'b1;
            end
            m_err = new_err || (m_err && !clear_err);
            m_edges++;
            if (d > 0) sb_q.push_back('{m_bin, m_err, m_edges});
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            logic exp_ch;
            exp_t ent;
            exp_ch = 1'b0;
            if (sb_q.size() > 0 && sb_q[0].e == m_edges) begin
                ent = sb_q.pop_front();
                exp_ch = 1'b1;
                chk("sb_binary", binary, ent.bin);
                chk("sb_step_err", step_err, ent.err);
            end
            chk("changed", changed, exp_ch);
            chk("binary", binary, m_bin);
            chk("step_err", step_err, m_err);
            chk("anode", anode, exp_anode);
            chk("seven_segment", seven_segment, exp_seg);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_binary"}, binary, 4'h0);
        chk({tag, "_changed"}, changed, 1'b0);
        chk({tag, "_step_err"}, step_err, 1'b0);
        chk({tag, "_anode"}, anode, 2'b10);
        chk({tag, "_seg"}, seven_segment, 7'b0000001);
    endtask

    task automatic do_reset(input logic [3:0] g);
        rst = 1'b0;
        gray = g;
        clear_err = 1'b0;
        cycles(2);
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] walk [4];
        walk = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};

        cycles(2);
        check_reset_outputs("por");
        rst = 1'b1;
        cycles(2 * RD + 3);

        do_reset(4'b1000);
        cycles(10);
        chk("first_sample_bin", binary, 4'hF);
        chk("first_sample_err", step_err, 1'b0);

        do_reset(4'b0000);
        cycles(10);
        foreach (walk[i]) begin
            gray = walk[i];
            cycles(10);
        end
        chk("walk_final_bin", binary, 4'h4);

        gray = 4'b0010;
        cycles(10);
        gray = 4'b0101;
        cycles(2 * RD + 4);
        chk("jump_err", step_err, 1'b1);

        gray = 4'b0110;
        cycles(10);
        gray = 4'b1001;
        cycles(2);
        clear_err = 1'b1;
        cycles(1);
        clear_err = 1'b0;
        cycles(5);
        chk("err_wins_over_clear", step_err, 1'b1);
        clear_err = 1'b1;
        cycles(1);
        clear_err = 1'b0;
        cycles(1);
        chk("lone_clear", step_err, 1'b0);

        repeat (400) begin
            int r;
            r = int'($urandom_range(0, 3));
            if (r == 0) gray = 4'($urandom);
            else if (r == 1) gray = gray ^ (4'b0001 << $urandom_range(0, 3));
            clear_err = ($urandom_range(0, 15) == 0);
            cycles(1);
        end
        clear_err = 1'b0;

        gray = 4'h0;
        cycles(6);
        gray = 4'hF;
        cycles(6);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        cycles(3);
        rst = 1'b1;
        cycles(3 * RD + 2);

        chk("queue_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
